// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS control slice (package mips_pkg):
// FSM state enum, opcode/func constants, ALU operation codes and datapath
// select encodings.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_ADDIEX,
        S_ADDIWB,
        S_BRANCH,
        S_JUMP,
        S_JAL
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // FSM-to-alu_ctrl request; IDLE yields 000 for states that do not use the ALU
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] ALUOP_IDLE = 2'b11;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PC source select
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Destination register select
    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle controller and the datapath.
// master = controller (drives enables/selects), slave = datapath.
interface multicycle_controller_if;
    logic [5:0] opc;
    logic [5:0] func;
    logic       zero;
    logic       pcen;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic [1:0] regdst;
    logic       writesel;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluoperation;
    logic [1:0] pcsrc;

    modport master (
        input  opc, func, zero,
        output pcen, iord, memread, memwrite, irwrite, memtoreg, regdst,
               writesel, regwrite, alusrca, alusrcb, aluoperation, pcsrc
    );

    modport slave (
        output opc, func, zero,
        input  pcen, iord, memread, memwrite, irwrite, memtoreg, regdst,
               writesel, regwrite, alusrca, alusrcb, aluoperation, pcsrc
    );
endinterface

// File: rtl/multicycle_controller_alu_ctrl.sv
// ALU control decode: maps the FSM's aluop request and the R-type func
// field to the 3-bit ALU operation.
module alu_ctrl
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] func,
    output logic [2:0] aluoperation
);

    // Decode ALU operation from request and func field
    always_comb begin
        aluoperation = ALU_AND;
        unique case (aluop)
            ALUOP_ADD:  aluoperation = ALU_ADD;
            ALUOP_SUB:  aluoperation = ALU_SUB;
            ALUOP_FUNC: begin
                case (func)
                    FN_ADD:  aluoperation = ALU_ADD;
                    FN_SUB:  aluoperation = ALU_SUB;
                    FN_AND:  aluoperation = ALU_AND;
                    FN_OR:   aluoperation = ALU_OR;
                    FN_SLT:  aluoperation = ALU_SLT;
                    default: aluoperation = ALU_ADD;
                endcase
            end
            default:    aluoperation = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle MIPS datapath.
// Optional feature macro: JAL_EN (compiles in the JAL state and jal decode;
// when undefined, opcode 000011 decodes as unknown and writesel stays 0).
module multicycle_controller
    import mips_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    multicycle_controller_if.master        bus
);

    state_t     state, next_state;

    logic       pcen_d, iord_d, memread_d, memwrite_d, irwrite_d, memtoreg_d;
    logic [1:0] regdst_d;
    logic       writesel_d, regwrite_d, alusrca_d;
    logic [1:0] alusrcb_d, pcsrc_d;
    logic [1:0] aluop_d;
    logic [2:0] aluoperation_d;

    alu_ctrl u_alu_ctrl (
        .aluop        (aluop_d),
        .func         (bus.func),
        .aluoperation (aluoperation_d)
    );

    // State register, asynchronously returned to FETCH by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    // Next-state and per-state output decode
    always_comb begin
        next_state = S_FETCH;
        pcen_d     = 1'b0;
        iord_d     = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        irwrite_d  = 1'b0;
        memtoreg_d = 1'b0;
        regdst_d   = RD_RT;
        writesel_d = 1'b0;
        regwrite_d = 1'b0;
        alusrca_d  = 1'b0;
        alusrcb_d  = SRCB_REG;
        pcsrc_d    = PC_ALU;
        aluop_d    = ALUOP_IDLE;

        case (state)
            S_FETCH: begin
                memread_d  = 1'b1;
                irwrite_d  = 1'b1;
                alusrcb_d  = SRCB_FOUR;
                aluop_d    = ALUOP_ADD;
                pcsrc_d    = PC_ALU;
                pcen_d     = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                alusrcb_d = SRCB_IMMSH;
                aluop_d   = ALUOP_ADD;
                case (bus.opc)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
`ifdef JAL_EN
                    OP_JAL:       next_state = S_JAL;
`endif
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca_d  = 1'b1;
                alusrcb_d  = SRCB_IMM;
                aluop_d    = ALUOP_ADD;
                next_state = (bus.opc == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord_d     = 1'b1;
                memread_d  = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                regdst_d   = RD_RT;
                memtoreg_d = 1'b1;
                regwrite_d = 1'b1;
            end
            S_MEMWR: begin
                iord_d     = 1'b1;
                memwrite_d = 1'b1;
            end
            S_EXEC: begin
                alusrca_d  = 1'b1;
                alusrcb_d  = SRCB_REG;
                aluop_d    = ALUOP_FUNC;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                regdst_d   = RD_RD;
                regwrite_d = 1'b1;
            end
            S_ADDIEX: begin
                alusrca_d  = 1'b1;
                alusrcb_d  = SRCB_IMM;
                aluop_d    = ALUOP_ADD;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                regdst_d   = RD_RT;
                regwrite_d = 1'b1;
            end
            S_BRANCH: begin
                alusrca_d = 1'b1;
                alusrcb_d = SRCB_REG;
                aluop_d   = ALUOP_SUB;
                pcsrc_d   = PC_ALUOUT;
                pcen_d    = bus.zero;
            end
            S_JUMP: begin
                pcsrc_d = PC_JUMP;
                pcen_d  = 1'b1;
            end
`ifdef JAL_EN
            S_JAL: begin
                pcsrc_d    = PC_JUMP;
                pcen_d     = 1'b1;
                regdst_d   = RD_RA;
                writesel_d = 1'b1;
                regwrite_d = 1'b1;
            end
`endif
            default: next_state = S_FETCH;
        endcase
    end

    // Reset holds every control line low so nothing is written while in reset
    assign bus.pcen         = ~rst & pcen_d;
    assign bus.iord         = ~rst & iord_d;
    assign bus.memread      = ~rst & memread_d;
    assign bus.memwrite     = ~rst & memwrite_d;
    assign bus.irwrite      = ~rst & irwrite_d;
    assign bus.memtoreg     = ~rst & memtoreg_d;
    assign bus.regdst       = rst ? '0 : regdst_d;
    assign bus.writesel     = ~rst & writesel_d;
    assign bus.regwrite     = ~rst & regwrite_d;
    assign bus.alusrca      = ~rst & alusrca_d;
    assign bus.alusrcb      = rst ? '0 : alusrcb_d;
    assign bus.aluoperation = rst ? '0 : aluoperation_d;
    assign bus.pcsrc        = rst ? '0 : pcsrc_d;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction expected
// control sequences are generated from the instruction semantics and
// compared cycle by cycle.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic [1:0] regdst;
        logic       writesel;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
    } ctl_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    ctl_t exp_q[$];

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t sample();
        ctl_t s;
        s.pcen     = bus.pcen;
        s.iord     = bus.iord;
        s.memread  = bus.memread;
        s.memwrite = bus.memwrite;
        s.irwrite  = bus.irwrite;
        s.memtoreg = bus.memtoreg;
        s.regdst   = bus.regdst;
        s.writesel = bus.writesel;
        s.regwrite = bus.regwrite;
        s.alusrca  = bus.alusrca;
        s.alusrcb  = bus.alusrcb;
        s.aluop    = bus.aluoperation;
        s.pcsrc    = bus.pcsrc;
        return s;
    endfunction

    function automatic logic [2:0] rtype_op(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Reference: list of control words an instruction produces, one per cycle
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
        ctl_t c;
        exp_q.delete();
        c = '0; c.memread = 1; c.irwrite = 1; c.alusrcb = 2'b01; c.aluop = 3'b010; c.pcen = 1;
        exp_q.push_back(c);
        c = '0; c.alusrcb = 2'b11; c.aluop = 3'b010;
        exp_q.push_back(c);
        case (op)
            6'b100011, 6'b101011: begin
                c = '0; c.alusrca = 1; c.alusrcb = 2'b10; c.aluop = 3'b010;
                exp_q.push_back(c);
                if (op == 6'b100011) begin
                    c = '0; c.iord = 1; c.memread = 1;
                    exp_q.push_back(c);
                    c = '0; c.memtoreg = 1; c.regwrite = 1;
                    exp_q.push_back(c);
                end else begin
                    c = '0; c.iord = 1; c.memwrite = 1;
                    exp_q.push_back(c);
                end
            end
            6'b000000: begin
                c = '0; c.alusrca = 1; c.aluop = rtype_op(fn);
                exp_q.push_back(c);
                c = '0; c.regdst = 2'b01; c.regwrite = 1;
                exp_q.push_back(c);
            end
            6'b001000: begin
                c = '0; c.alusrca = 1; c.alusrcb = 2'b10; c.aluop = 3'b010;
                exp_q.push_back(c);
                c = '0; c.regwrite = 1;
                exp_q.push_back(c);
            end
            6'b000100: begin
                c = '0; c.alusrca = 1; c.aluop = 3'b110; c.pcsrc = 2'b01; c.pcen = z;
                exp_q.push_back(c);
            end
            6'b000010: begin
                c = '0; c.pcsrc = 2'b10; c.pcen = 1;
                exp_q.push_back(c);
            end
`ifdef JAL_EN
            6'b000011: begin
                c = '0; c.pcsrc = 2'b10; c.pcen = 1; c.regdst = 2'b10; c.writesel = 1; c.regwrite = 1;
                exp_q.push_back(c);
            end
`endif
            default: ;
        endcase
    endtask

    // Starts at a negedge with the DUT in FETCH; ends likewise for the next one
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input string tag);
        ctl_t got;
        build(op, fn, z);
        bus.opc  = op;
        bus.func = fn;
        bus.zero = z;
        for (int i = 0; i < exp_q.size(); i++) begin
            #1;
            got = sample();
            n_tests++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s cyc%0d op=%b fn=%b z=%b: got %h expected %h",
                         tag, i, op, fn, z, got, exp_q[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_zero(input string tag);
        ctl_t got;
        got = sample();
        n_tests++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL %s: got %h expected 0", tag, got);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check_zero("reset_hold");
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lw();
        run_instr(6'b100011, 6'h15, 1'b0, "lw");
        run_instr(6'b100011, 6'h00, 1'b1, "lw2");
    endtask

    task automatic test_rtype();
        run_instr(6'b000000, 6'b100010, 1'b0, "r_sub");
        run_instr(6'b000000, 6'b101010, 1'b0, "r_slt");
        run_instr(6'b000000, 6'b100100, 1'b1, "r_and");
        run_instr(6'b000000, 6'b100101, 1'b0, "r_or");
        run_instr(6'b000000, 6'b100000, 1'b0, "r_add");
        run_instr(6'b000000, 6'b111111, 1'b0, "r_unk");
    endtask

    task automatic test_beq();
        run_instr(6'b000100, 6'h00, 1'b1, "beq_taken");
        run_instr(6'b000100, 6'h00, 1'b0, "beq_not");
    endtask

    task automatic test_sw_unknown();
        run_instr(6'b101011, 6'h2a, 1'b0, "sw");
        run_instr(6'b111111, 6'h20, 1'b1, "unknown");
        run_instr(6'b001000, 6'h00, 1'b0, "addi");
        run_instr(6'b000010, 6'h00, 1'b0, "j");
    endtask

    task automatic test_jal();
        run_instr(6'b000011, 6'h00, 1'b0, "jal");
        run_instr(6'b000011, 6'h20, 1'b1, "jal2");
    endtask

    task automatic test_reset_midinstr();
        ctl_t got;
        build(6'b100011, 6'h00, 1'b0);
        bus.opc = 6'b100011;
        for (int i = 0; i < 4; i++) begin
            #1;
            got = sample();
            n_tests++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("FAIL midrst_pre cyc%0d: got %h expected %h", i, got, exp_q[i]);
            end
            if (i < 3) @(negedge clk);
        end
        #2 rst = 1'b1;
        #1 check_zero("midrst_immediate");
        @(negedge clk);
        #1 check_zero("midrst_held");
        @(negedge clk);
        rst = 1'b0;
        run_instr(6'b100011, 6'h00, 1'b0, "midrst_after");
    endtask

    task automatic test_random();
        logic [5:0] ops[7];
        logic [5:0] fns[5];
        logic [5:0] op, fn;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000011};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int n = 0; n < 200; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr(op, fn, 1'($urandom), "random");
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.opc  = '0;
        bus.func = '0;
        bus.zero = 1'b0;
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_sw_unknown();
        test_jal();
        test_reset_midinstr();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
